mid_bus_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single 4-bit mid[] datapath between NREQ requesters.

---
 rtl/mid_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 32 +++
 rtl/mid_bus_arbiter.sv | 113 +++++++++++
 tb/tb_mid_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mid_arb_pkg.sv
// Shared types and default sizing for the mid bus arbiter.
// Provides the arbiter state enum and the default bus geometry constants.
package mid_arb_pkg;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam int NREQ_D      = 4;
   localparam int WIDTH_D     = 4;
   localparam int MAX_BURST_D = 8;
   localparam int SRC_W       = $clog2(NREQ_D);

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set req bit scanning ptr+1, ptr+2, ... mod N.
// Ports: req/ptr in; onehot, idx and any (some req set) out.
module rr_pick
   import mid_arb_pkg::*;
#(
   parameter int N  = NREQ_D,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [SW-1:0] idx,
   output logic          any
);

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      // i runs 1..N so the slot at ptr itself is scanned last
      for (int i = 1; i <= N; i++) begin
         logic [SW-1:0] kk;
         kk = SW'((int'(ptr) + i) % N);
         if (!any && req[kk]) begin
            any        = 1'b1;
            onehot[kk] = 1'b1;
            idx        = kk;
         end
      end
   end

endmodule

// File: rtl/mid_bus_arbiter.sv
// Round-robin arbiter sharing the mid[] bus between NREQ requesters with burst limit.
// Ports: clk, rst, req, req_data, req_last in; gnt, dut_valid, dut_data, dut_src out; dut_ready in.
module mid_bus_arbiter
   import mid_arb_pkg::*;
#(
   parameter int NREQ      = NREQ_D,
   parameter int WIDTH     = WIDTH_D,
   parameter int MAX_BURST = MAX_BURST_D
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          gnt,
   output logic                     dut_valid,
   output logic [WIDTH-1:0]         dut_data,
   output logic [$clog2(NREQ)-1:0]  dut_src,
   input  logic                     dut_ready
);

   localparam int SW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   state_t          state, state_d;
   logic [SW-1:0]   ptr, ptr_d;
   logic [SW-1:0]   src_d;
   logic [NREQ-1:0] gnt_d;
   logic [BW-1:0]   beat_cnt, cnt_d;

   logic [NREQ-1:0] pick_oh;
   logic [SW-1:0]   pick_idx;
   logic            pick_any;
   logic            beat;
   logic            burst_end;

   logic [WIDTH-1:0] slice [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign slice[i] = req_data[i*WIDTH +: WIDTH];
   end

   // ptr always equals the owner while in GRANT, so the owner ranks last
   rr_pick #(.N(NREQ), .SW(SW)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign dut_valid = (state == GRANT) && req[dut_src];
   assign dut_data  = dut_valid ? slice[dut_src] : '0;
   assign beat      = dut_valid && dut_ready;

   // withdraw ends the burst with no beat; last and max-length merge into one end
   assign burst_end = (state == GRANT) &&
                      (!req[dut_src] ||
                       (beat && (req_last[dut_src] ||
                                 beat_cnt == BW'(MAX_BURST - 1))));

   always_comb begin
      state_d = state;
      gnt_d   = gnt;
      src_d   = dut_src;
      ptr_d   = ptr;
      cnt_d   = beat_cnt;
      unique case (state)
         IDLE: begin
            if (pick_any) begin
               state_d = GRANT;
               gnt_d   = pick_oh;
               src_d   = pick_idx;
               ptr_d   = pick_idx;
            end
         end
         GRANT: begin
            if (burst_end) begin
               cnt_d = '0;
               if (pick_any) begin
                  gnt_d = pick_oh;
                  src_d = pick_idx;
                  ptr_d = pick_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  src_d   = '0;
               end
            end else if (beat) begin
               cnt_d = beat_cnt + BW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         dut_src  <= '0;
         ptr      <= SW'(NREQ - 1);
         beat_cnt <= '0;
      end else begin
         state    <= state_d;
         gnt      <= gnt_d;
         dut_src  <= src_d;
         ptr      <= ptr_d;
         beat_cnt <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mid_bus_arbiter.sv
// Directed self-checking bench for mid_bus_arbiter (NREQ=4, WIDTH=4, MAX_BURST=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mid_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  gnt;
   logic        dut_valid;
   logic [3:0]  dut_data;
   logic [1:0]  dut_src;
   logic        dut_ready;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   mid_bus_arbiter #(.NREQ(4), .WIDTH(4), .MAX_BURST(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .req_last  (req_last),
      .gnt       (gnt),
      .dut_valid (dut_valid),
      .dut_data  (dut_data),
      .dut_src   (dut_src),
      .dut_ready (dut_ready)
   );

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      req_last = '0;
      dut_ready = 1'b0;
      req_data = 16'h8765;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b1111;
      req_last = 4'b1111;
      req_data = 16'h8765;
      dut_ready = 1'b1;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0000 || dut_valid !== 1'b0 ||
          dut_data !== 4'h0 || dut_src !== 2'd0)
         $display("FAIL reset: gnt=%b valid=%b data=%h src=%0d want 0000/0/0/0",
                  gnt, dut_valid, dut_data, dut_src);
      else pass_cnt++;
      total++;
      if (dut.beat_cnt !== 4'd0)
         $display("FAIL reset_cnt: beat_cnt=%0d want 0", dut.beat_cnt);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] exp_d [5] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h5};
      logic [1:0] exp_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (gnt !== exp_g[i] || dut_src !== exp_s[i] ||
             dut_valid !== 1'b1 || dut_data !== exp_d[i])
            $display("FAIL rr[%0d]: gnt=%b src=%0d valid=%b data=%h want %b/%0d/1/%h",
                     i, gnt, dut_src, dut_valid, dut_data,
                     exp_g[i], exp_s[i], exp_d[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_idle_ready();
      do_reset();
      dut_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (gnt !== 4'b0000 || dut_valid !== 1'b0 || dut_data !== 4'h0)
            $display("FAIL idle[%0d]: gnt=%b valid=%b data=%h want 0000/0/0",
                     i, gnt, dut_valid, dut_data);
         else pass_cnt++;
      end
   endtask

   task automatic test_max_burst();
      do_reset();
      req = 4'b0110;
      dut_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if (gnt !== 4'b0010 || dut_src !== 2'd1 || dut_valid !== 1'b1 ||
             dut.beat_cnt !== 4'(i))
            $display("FAIL burst[%0d]: gnt=%b src=%0d valid=%b cnt=%0d want 0010/1/1/%0d",
                     i, gnt, dut_src, dut_valid, dut.beat_cnt, i);
         else pass_cnt++;
      end
      @(negedge clk);
      total++;
      if (gnt !== 4'b0100 || dut_src !== 2'd2 || dut_valid !== 1'b1 ||
          dut_data !== 4'h7 || dut.beat_cnt !== 4'd0)
         $display("FAIL burst_rot: gnt=%b src=%0d valid=%b data=%h cnt=%0d want 0100/2/1/7/0",
                  gnt, dut_src, dut_valid, dut_data, dut.beat_cnt);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      do_reset();
      req = 4'b0001;
      dut_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      dut_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (dut_valid !== 1'b1 || dut_data !== 4'h5 || gnt !== 4'b0001 ||
             dut_src !== 2'd0 || dut.beat_cnt !== 4'd2)
            $display("FAIL stall[%0d]: valid=%b data=%h gnt=%b src=%0d cnt=%0d want 1/5/0001/0/2",
                     i, dut_valid, dut_data, gnt, dut_src, dut.beat_cnt);
         else pass_cnt++;
      end
      dut_ready = 1'b1;
      @(negedge clk);
      total++;
      if (dut.beat_cnt !== 4'd3 || gnt !== 4'b0001)
         $display("FAIL stall_resume: cnt=%0d gnt=%b want 3/0001",
                  dut.beat_cnt, gnt);
      else pass_cnt++;
   endtask

   task automatic test_withdraw();
      do_reset();
      req = 4'b1100;
      dut_ready = 1'b1;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0100)
         $display("FAIL wd_grant: gnt=%b want 0100", gnt);
      else pass_cnt++;
      @(negedge clk);
      req = 4'b1000;
      #1;
      total++;
      if (dut_valid !== 1'b0 || dut_data !== 4'h0 || dut.beat_cnt !== 4'd1)
         $display("FAIL wd_drop: valid=%b data=%h cnt=%0d want 0/0/1",
                  dut_valid, dut_data, dut.beat_cnt);
      else pass_cnt++;
      @(negedge clk);
      total++;
      if (gnt !== 4'b1000 || dut_src !== 2'd3 || dut_valid !== 1'b1 ||
          dut_data !== 4'h8 || dut.beat_cnt !== 4'd0)
         $display("FAIL wd_next: gnt=%b src=%0d valid=%b data=%h cnt=%0d want 1000/3/1/8/0",
                  gnt, dut_src, dut_valid, dut_data, dut.beat_cnt);
      else pass_cnt++;
   endtask

   task automatic test_last_and_max();
      do_reset();
      req = 4'b0011;
      dut_ready = 1'b1;
      for (int i = 0; i < 7; i++) @(negedge clk);
      req_last = 4'b0001;
      @(negedge clk);
      req_last = 4'b0000;
      total++;
      if (gnt !== 4'b0010 || dut_src !== 2'd1 || dut.beat_cnt !== 4'd0)
         $display("FAIL last_max: gnt=%b src=%0d cnt=%0d want 0010/1/0",
                  gnt, dut_src, dut.beat_cnt);
      else pass_cnt++;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0010 || dut.beat_cnt !== 4'd1)
         $display("FAIL last_max_hold: gnt=%b cnt=%0d want 0010/1",
                  gnt, dut.beat_cnt);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0010;
      dut_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (gnt !== 4'b0000 || dut_valid !== 1'b0 || dut_src !== 2'd0 ||
          dut_data !== 4'h0)
         $display("FAIL async_rst: gnt=%b valid=%b src=%0d data=%h want 0000/0/0/0",
                  gnt, dut_valid, dut_src, dut_data);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1000;
      @(negedge clk);
      total++;
      if (gnt !== 4'b1000 || dut_src !== 2'd3 || dut_data !== 4'h8)
         $display("FAIL post_rst: gnt=%b src=%0d data=%h want 1000/3/8",
                  gnt, dut_src, dut_data);
      else pass_cnt++;
   endtask

   task automatic test_sole_regrant();
      do_reset();
      req = 4'b0001;
      dut_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         total++;
         if (gnt !== 4'b0001 || dut_valid !== 1'b1 ||
             dut.beat_cnt !== 4'(i % 8))
            $display("FAIL sole[%0d]: gnt=%b valid=%b cnt=%0d want 0001/1/%0d",
                     i, gnt, dut_valid, dut.beat_cnt, i % 8);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_idle_ready();
      test_max_burst();
      test_stall();
      test_withdraw();
      test_last_and_max();
      test_async_reset();
      test_sole_regrant();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
